// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the byte-addressed RAM controller.
//   - size_t    : access-size encodings carried on the Size port
//   - state_t   : controller FSM states
//   - DEF_*     : default DEPTH / WAIT_STATES
//   - byte_count: number of bytes an access size touches (0 for reserved)
package ram_pkg;

   localparam int DEF_DEPTH       = 512;
   localparam int DEF_WAIT_STATES = 2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [2:0] byte_count(input size_t s);
      case (s)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/ram_align_chk.sv
// ram_align_chk: combinational legality check of a latched access.
//   addr  : latched byte address
//   size  : latched access size
//   fault : misaligned, reserved size, or any touched byte beyond DEPTH-1
//   lanes : byte enables, bit k selects Mem[addr+k]; all zero on a fault
module ram_align_chk
   import ram_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] addr,
   input  size_t         size,
   output logic          fault,
   output logic [3:0]    lanes
);

   // Two spare bits so addr+3 never wraps before the range compare.
   localparam logic [AW+1:0] LAST = (AW+2)'(DEPTH - 1);

   logic [2:0]    nb;
   logic [AW+1:0] end_addr;

   always_comb begin
      nb       = byte_count(size);
      end_addr = {2'b00, addr} + (AW+2)'(nb) - (AW+2)'(1);
      fault    = 1'b0;
      lanes    = 4'b0000;
      case (size)
         SZ_BYTE: lanes = 4'b0001;
         SZ_HALF: begin
            lanes = 4'b0011;
            fault = addr[0];
         end
         SZ_WORD: begin
            lanes = 4'b1111;
            fault = |addr[1:0];
         end
         default: fault = 1'b1;
      endcase
      if (nb != 3'd0 && end_addr > LAST) fault = 1'b1;
      if (fault) lanes = 4'b0000;
   end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: MFA/MOC handshake controller around a big-endian byte RAM.
//   Clk     : rising-edge clock
//   Clear   : asynchronous active-low reset (Mem is not reset)
//   MFA     : request; sampled in IDLE, held high keeps MOC asserted in DONE
//   RW      : 1 read, 0 write
//   Size    : 00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   Addr    : byte address
//   DataIn  : right-justified write data
//   DataOut : right-justified, zero-extended read data (0 after a fault)
//   MOC     : access complete
//   Err     : access fault, meaningful while MOC is high
module ram_ctrl
   import ram_pkg::*;
#(
   parameter  int DEPTH       = DEF_DEPTH,
   parameter  int WAIT_STATES = DEF_WAIT_STATES,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          Clear,
   input  logic          MFA,
   input  logic          RW,
   input  logic [1:0]    Size,
   input  logic [AW-1:0] Addr,
   input  logic [31:0]   DataIn,
   output logic [31:0]   DataOut,
   output logic          MOC,
   output logic          Err
);

   // +2 keeps the counter at least one bit wide when WAIT_STATES is 0.
   localparam int CW = $clog2(WAIT_STATES + 2);

   logic [7:0] Mem [DEPTH];

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [AW-1:0]  addr_q;
   logic           rw_q;
   size_t          size_q;
   logic [31:0]    wdata_q;

   logic           fault;
   logic [3:0]     lanes;
   logic           access;
   logic [3:0][AW-1:0] idx;
   logic [3:0][7:0]    rb;
   logic [31:0]    rword;
   logic [31:0]    wword;

   ram_align_chk #(.DEPTH(DEPTH)) u_chk (
      .addr  (addr_q),
      .size  (size_q),
      .fault (fault),
      .lanes (lanes)
   );

   assign access = (state == BUSY) && (cnt == CW'(WAIT_STATES));

   // Lane k is Mem[addr+k]; lane 0 is the most significant byte of the
   // access. Reads and writes are built left-justified in lane order and
   // shifted into place by size.
   always_comb begin
      rword = '0;
      wword = wdata_q;
      for (int k = 0; k < 4; k++) begin
         idx[k] = addr_q + AW'(k);
         rb[k]  = lanes[k] ? Mem[idx[k]] : 8'h00;
      end
      case (size_q)
         SZ_BYTE: begin
            rword = {24'h0, rb[0]};
            wword = {wdata_q[7:0], 24'h0};
         end
         SZ_HALF: begin
            rword = {16'h0, rb[0], rb[1]};
            wword = {wdata_q[15:0], 16'h0};
         end
         SZ_WORD: begin
            rword = {rb[0], rb[1], rb[2], rb[3]};
            wword = wdata_q;
         end
         default: begin
            rword = '0;
            wword = wdata_q;
         end
      endcase
   end

   // Storage has no reset. The Clear term makes it explicit that nothing
   // can be written once reset is asserted (the FSM is also forced idle).
   always_ff @(posedge Clk) begin
      if (Clear && access && !rw_q && !fault) begin
         for (int k = 0; k < 4; k++) begin
            if (lanes[k]) Mem[idx[k]] <= wword[8*(3-k) +: 8];
         end
      end
   end

   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) begin
         state   <= IDLE;
         cnt     <= '0;
         MOC     <= 1'b0;
         Err     <= 1'b0;
         DataOut <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MFA) begin
                  addr_q  <= Addr;
                  rw_q    <= RW;
                  size_q  <= size_t'(Size);
                  wdata_q <= DataIn;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               // MFA is ignored here: a started access always completes.
               if (cnt == CW'(WAIT_STATES)) begin
                  state <= DONE;
                  MOC   <= 1'b1;
                  Err   <= fault;
                  if (fault)     DataOut <= '0;
                  else if (rw_q) DataOut <= rword;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (!MFA) begin
                  state <= IDLE;
                  MOC   <= 1'b0;
                  Err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized self-checking bench for ram_ctrl against a
// byte-array reference model.
module tb_ram_ctrl;

   localparam int DEPTH = 512;
   localparam int WS    = 2;

   logic        Clk;
   logic        Clear;
   logic        MFA;
   logic        RW;
   logic [1:0]  Size;
   logic [8:0]  Addr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MOC;
   logic        Err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mm [DEPTH];
   logic [31:0] exp_dout = '0;

   ram_ctrl dut (
      .Clk     (Clk),
      .Clear   (Clear),
      .MFA     (MFA),
      .RW      (RW),
      .Size    (Size),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .MOC     (MOC),
      .Err     (Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Reference: an access touches n bytes starting at a, must be n-aligned
   // and fit inside DEPTH. Reads assemble bytes MSB-first.
   task automatic model(input logic rw, input logic [1:0] sz, input int a,
                        input logic [31:0] d, output logic e);
      int n;
      n = nbytes(sz);
      e = (n == 0) || (a % n != 0) || (a + n > DEPTH);
      if (e) exp_dout = '0;
      else if (rw) begin
         exp_dout = '0;
         for (int i = 0; i < n; i++) exp_dout = (exp_dout << 8) | {24'h0, mm[a+i]};
      end else begin
         for (int i = 0; i < n; i++) mm[a+i] = 8'(d >> (8*(n-1-i)));
      end
   endtask

   // One request, MFA dropped right after sampling and inputs scrambled.
   // lat counts edges after the sampling edge until MOC is seen.
   task automatic access(input logic rw, input logic [1:0] sz, input logic [8:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [31:0] dout, output logic e);
      @(negedge Clk);
      MFA = 1'b1; RW = rw; Size = sz; Addr = a; DataIn = d;
      @(posedge Clk);
      @(negedge Clk);
      MFA = 1'b0; RW = ~rw; Size = 2'($urandom); Addr = 9'($urandom); DataIn = $urandom;
      lat = 0;
      while (!MOC && lat < 50) begin
         @(posedge Clk);
         lat++;
         @(negedge Clk);
      end
      dout = DataOut;
      e    = Err;
   endtask

   task automatic test_reset;
      Clear = 1'b0; MFA = 1'b0; RW = 1'b0; Size = 2'b00; Addr = '0; DataIn = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      checks++; if (MOC !== 1'b0) begin errors++; $display("FAIL reset_moc got=%b exp=0", MOC); end
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", Err); end
      checks++; if (DataOut !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", DataOut); end
      Clear = 1'b1;
   endtask

   task automatic test_word_read;
      int lat; logic [31:0] dout; logic e, me;
      access(1'b1, 2'b10, 9'd0, 32'h0, lat, dout, e);
      model(1'b1, 2'b10, 0, 32'h0, me);
      checks++; if (dout !== 32'h12345678) begin errors++; $display("FAIL word_read_data got=%h exp=12345678", dout); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_read_err got=%b exp=0", e); end
      checks++; if (lat != WS + 1) begin errors++; $display("FAIL word_read_latency got=%0d exp=%0d", lat, WS + 1); end
      @(negedge Clk);
      checks++; if (MOC !== 1'b0) begin errors++; $display("FAIL moc_pulse got=%b exp=0", MOC); end
   endtask

   task automatic test_byte_write_half_read;
      int lat; logic [31:0] dout, d; logic e, me; logic [7:0] pre4;
      pre4 = mm[4];
      d = $urandom; d[7:0] = 8'hAB;
      access(1'b0, 2'b00, 9'd5, d, lat, dout, e);
      model(1'b0, 2'b00, 5, d, me);
      checks++; if (dout !== 32'h12345678) begin errors++; $display("FAIL write_holds_dout got=%h exp=12345678", dout); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL byte_write_err got=%b exp=0", e); end
      access(1'b1, 2'b01, 9'd4, 32'h0, lat, dout, e);
      model(1'b1, 2'b01, 4, 32'h0, me);
      checks++; if (dout !== {16'h0, pre4, 8'hAB}) begin errors++; $display("FAIL half_read_data got=%h exp=%h", dout, {16'h0, pre4, 8'hAB}); end
      checks++; if (dut.Mem[5] !== 8'hAB) begin errors++; $display("FAIL mem5 got=%h exp=ab", dut.Mem[5]); end
      checks++; if (dut.Mem[4] !== pre4) begin errors++; $display("FAIL mem4 got=%h exp=%h", dut.Mem[4], pre4); end
   endtask

   task automatic test_faults;
      int lat; logic [31:0] dout; logic e, me;
      logic [1:0]  fsz [4] = '{2'b10, 2'b11, 2'b11, 2'b01};
      logic        frw [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [8:0]  fad [4] = '{9'd2, 9'd0, 9'd0, 9'd1};
      for (int i = 0; i < 4; i++) begin
         access(frw[i], fsz[i], fad[i], 32'hCAFEF00D, lat, dout, e);
         model(frw[i], fsz[i], int'(fad[i]), 32'hCAFEF00D, me);
         checks++; if (e !== 1'b1) begin errors++; $display("FAIL fault%0d_err got=%b exp=1", i, e); end
         checks++; if (dout !== 32'h0) begin errors++; $display("FAIL fault%0d_dout got=%h exp=0", i, dout); end
         checks++; if (lat != WS + 1) begin errors++; $display("FAIL fault%0d_moc lat=%0d exp=%0d", i, lat, WS + 1); end
      end
      for (int i = 0; i < 6; i++) begin
         checks++; if (dut.Mem[i] !== mm[i]) begin errors++; $display("FAIL fault_mem%0d got=%h exp=%h", i, dut.Mem[i], mm[i]); end
      end
   endtask

   task automatic test_boundary;
      int lat; logic [31:0] dout; logic e, me;
      logic [1:0] bsz [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
      logic [8:0] bad [4] = '{9'd508, 9'd510, 9'd511, 9'd510};
      for (int i = 0; i < 4; i++) begin
         access(1'b1, bsz[i], bad[i], 32'h0, lat, dout, e);
         model(1'b1, bsz[i], int'(bad[i]), 32'h0, me);
         checks++; if (e !== me) begin errors++; $display("FAIL bound%0d_err got=%b exp=%b", i, e, me); end
         checks++; if (dout !== exp_dout) begin errors++; $display("FAIL bound%0d_dout got=%h exp=%h", i, dout, exp_dout); end
      end
   endtask

   task automatic test_hold;
      int lat; logic me; logic [7:0] pre100;
      pre100 = mm[100];
      model(1'b1, 2'b10, 0, 32'h0, me);
      @(negedge Clk);
      MFA = 1'b1; RW = 1'b1; Size = 2'b10; Addr = 9'd0; DataIn = '0;
      lat = 0;
      do begin @(posedge Clk); lat++; @(negedge Clk); end while (!MOC && lat < 50);
      checks++; if (lat != WS + 2) begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", lat, WS + 2); end
      // While held, present a write that must not be performed.
      RW = 1'b0; Size = 2'b00; Addr = 9'd100; DataIn = 32'h0000005A ^ {24'h0, pre100};
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk); @(negedge Clk);
         checks++; if (MOC !== 1'b1 || DataOut !== exp_dout) begin
            errors++; $display("FAIL hold_cycle%0d moc=%b dout=%h exp moc=1 dout=%h", i, MOC, DataOut, exp_dout);
         end
      end
      MFA = 1'b0;
      @(posedge Clk); @(negedge Clk);
      checks++; if (MOC !== 1'b0) begin errors++; $display("FAIL hold_release_moc got=%b exp=0", MOC); end
      checks++; if (dut.Mem[100] !== pre100) begin errors++; $display("FAIL hold_no_second got=%h exp=%h", dut.Mem[100], pre100); end
      // Request right away: accepted on the very next edge.
      MFA = 1'b1; RW = 1'b1; Size = 2'b00; Addr = 9'd100;
      lat = 0;
      do begin @(posedge Clk); lat++; @(negedge Clk); end while (!MOC && lat < 50);
      model(1'b1, 2'b00, 100, 32'h0, me);
      checks++; if (lat != WS + 2) begin errors++; $display("FAIL next_accept got=%0d exp=%0d", lat, WS + 2); end
      checks++; if (DataOut !== exp_dout) begin errors++; $display("FAIL next_data got=%h exp=%h", DataOut, exp_dout); end
      MFA = 1'b0;
      @(posedge Clk);
   endtask

   task automatic test_random;
      int lat, n, a; logic [31:0] dout, d; logic e, me, rw; logic [1:0] sz;
      for (int t = 0; t < 60; t++) begin
         rw = 1'($urandom);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         n  = nbytes(sz);
         a  = $urandom_range(0, DEPTH - 1);
         if (n > 0 && $urandom_range(0, 3) != 0) a = a - (a % n);
         d  = $urandom;
         access(rw, sz, 9'(a), d, lat, dout, e);
         model(rw, sz, a, d, me);
         checks++; if (e !== me || dout !== exp_dout || lat != WS + 1) begin
            errors++;
            $display("FAIL rand%0d rw=%b sz=%b a=%0d got err=%b dout=%h lat=%0d exp err=%b dout=%h lat=%0d",
                     t, rw, sz, a, e, dout, lat, me, exp_dout, WS + 1);
         end
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      @(negedge Clk);
      MFA = 1'b1; RW = 1'b0; Size = 2'b10; Addr = 9'd8; DataIn = 32'hDEADBEEF;
      @(posedge Clk); @(negedge Clk);
      MFA = 1'b0;
      @(posedge Clk); #1;
      Clear = 1'b0;
      #1;
      checks++; if (MOC !== 1'b0 || Err !== 1'b0 || DataOut !== 32'h0) begin
         errors++; $display("FAIL busy_reset moc=%b err=%b dout=%h exp 0/0/0", MOC, Err, DataOut);
      end
      repeat (4) @(posedge Clk);
      @(negedge Clk); Clear = 1'b1;
      repeat (4) @(posedge Clk);
      @(negedge Clk);
      exp_dout = '0;
      for (int i = 8; i < 12; i++) begin
         checks++; if (dut.Mem[i] !== mm[i]) begin errors++; $display("FAIL reset_nowrite%0d got=%h exp=%h", i, dut.Mem[i], mm[i]); end
      end
      // Reset while MOC is held high must drop it without waiting for a clock.
      MFA = 1'b1; RW = 1'b1; Size = 2'b10; Addr = 9'd0;
      lat = 0;
      do begin @(posedge Clk); lat++; @(negedge Clk); end while (!MOC && lat < 50);
      checks++; if (MOC !== 1'b1 || DataOut !== 32'h12345678) begin
         errors++; $display("FAIL pre_reset_done moc=%b dout=%h exp 1/12345678", MOC, DataOut);
      end
      #2 Clear = 1'b0;
      #1;
      checks++; if (MOC !== 1'b0 || DataOut !== 32'h0 || Err !== 1'b0) begin
         errors++; $display("FAIL done_reset moc=%b err=%b dout=%h exp 0/0/0", MOC, Err, DataOut);
      end
      MFA = 1'b0;
      @(negedge Clk); Clear = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_mem_final;
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (dut.Mem[i] !== mm[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL mem_final mismatching_bytes=%0d exp=0", bad); end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mm[i] = 8'($urandom);
         dut.Mem[i] = mm[i];
      end
      mm[0] = 8'h12; mm[1] = 8'h34; mm[2] = 8'h56; mm[3] = 8'h78;
      for (int i = 0; i < 4; i++) dut.Mem[i] = mm[i];

      test_reset;
      test_word_read;
      test_byte_write_half_read;
      test_faults;
      test_boundary;
      test_hold;
      test_random;
      test_reset_mid;
      test_mem_final;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
